// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, R/W bit encoding, default target address.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA and derives SCL edge pulses plus START/STOP events.
// Latency: events are combinational on the last sync stage; a consumer register sees them SYNC_STAGES+1 clk after the pin.
// Backpressure: none; events are one-clk pulses that the consumer must take.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;

    // Synchroniser chains plus one delayed copy for edge detection; idle-high at reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SCL edge coinciding with an SDA edge is not a START/STOP.
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: matches OWN_ADDR, shifts in data bytes, ACKs on SDA, presents bytes on valid/ready.
// Latency: byte appears on rx_data/rx_valid SYNC_STAGES+1 clk after the 8th SCL rise at the pin.
// Backpressure: a byte arriving while rx_valid is still held is NACKed, dropped, and flagged by an overrun pulse.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR    = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overrun
);

    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       bus_start;
    logic       bus_stop;
    logic [7:0] shift_d;

    i2c_state_e state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       ack_q;
    logic       ack_phase_q;
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       busy_q;
    logic       overrun_q;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    assign shift_d = {shift_q[6:0], sda_s};

    // Protocol FSM, shifter and output handshake; START/STOP override any SCL edge in the same clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            ack_q       <= 1'b0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (bus_stop) begin
                state_q     <= IDLE;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                bit_cnt_q   <= 3'd0;
                ack_phase_q <= 1'b0;
            end else if (bus_start) begin
                state_q     <= ADDR;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                bit_cnt_q   <= 3'd0;
                ack_phase_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (shift_d[7:1] == OWN_ADDR && shift_d[0] == I2C_RW_WRITE) begin
                                    state_q     <= ADDR_ACK;
                                    busy_q      <= 1'b1;
                                    ack_q       <= 1'b1;
                                    ack_phase_q <= 1'b0;
                                end else begin
                                    state_q <= IGNORE;
                                end
                            end
                        end
                    end
                    // Both ACK slots: drive on the first SCL fall, release on the next one.
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= ack_q;
                                ack_phase_q <= 1'b1;
                            end else begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                bit_cnt_q   <= 3'd0;
                                state_q     <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                // A byte being consumed this clk frees the slot for the new one.
                                if (rx_valid_q && !rx_ready) begin
                                    overrun_q <= 1'b1;
                                    ack_q     <= 1'b0;
                                end else begin
                                    rx_data_q  <= shift_d;
                                    rx_valid_q <= 1'b1;
                                    ack_q      <= 1'b1;
                                end
                                ack_phase_q <= 1'b0;
                                state_q     <= DATA_ACK;
                            end
                        end
                    end
                    IGNORE: ;
                    default: begin
                        state_q  <= IDLE;
                        sda_oe_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: bit-banged I2C master on an open-drain SDA model.
// Latency: expected bytes are queued when sent and checked when the DUT hands them over.
// Backpressure: rx_ready is driven per test to exercise hold and overrun.
module tb_i2c_target_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_drv;
    logic       sda_drv;
    logic       rx_ready;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       overrun;
    logic       sda_bus;

    int n_cmp = 0;
    int n_err = 0;
    int oe_pulses = 0;
    int ovr_pulses = 0;
    int vld_cycles = 0;
    logic oe_prev = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Wired-AND bus: the target can only pull SDA low.
    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target_rx #(
        .OWN_ADDR    (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_drv),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b, output logic smp);
        tick(3);
        sda_drv = b;
        tick(3);
        scl_drv = 1'b1;
        tick(4);
        smp = sda_bus;
        tick(4);
        scl_drv = 1'b0;
        tick(2);
    endtask

    task automatic i2c_start();
        if (!scl_drv) begin
            tick(3);
            sda_drv = 1'b1;
            tick(3);
            scl_drv = 1'b1;
            tick(4);
        end else begin
            sda_drv = 1'b1;
            tick(4);
        end
        sda_drv = 1'b0;
        tick(4);
        scl_drv = 1'b0;
        tick(2);
    endtask

    task automatic i2c_stop();
        tick(3);
        sda_drv = 1'b0;
        tick(3);
        scl_drv = 1'b1;
        tick(4);
        sda_drv = 1'b1;
        tick(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) send_bit(b[i], d);
        send_bit(1'b1, d);
        ack = ~d;
    endtask

    // Monitor: counts output events and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (sda_oe && !oe_prev) begin
                oe_pulses <= oe_pulses + 1;
                chk("oe_rise_scl_low", scl_drv, 0);
            end
            if (overrun) ovr_pulses <= ovr_pulses + 1;
            if (rx_valid) vld_cycles <= vld_cycles + 1;
            if (rx_valid && rx_ready) begin
                chk("rx_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("rx_data", rx_data, exp_q.pop_front());
            end
        end
        oe_prev <= sda_oe;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic d;
        int   oe0, v0, ov0;
        logic [7:0] b99;

        reset    = 1'b0;
        scl_drv  = 1'b1;
        sda_drv  = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b1;
        tick(5);

        // Basic write of 0xAA with consumer always ready.
        oe0 = oe_pulses; v0 = vld_cycles;
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t1_addr_ack", ack, 1);
        chk("t1_busy", busy, 1);
        exp_q.push_back(8'hAA);
        send_byte(8'hAA, ack);
        chk("t1_data_ack", ack, 1);
        i2c_stop();
        tick(2);
        chk("t1_busy_end", busy, 0);
        chk("t1_oe_pulses", oe_pulses - oe0, 2);
        chk("t1_vld_cycles", vld_cycles - v0, 1);
        chk("t1_queue", exp_q.size(), 0);

        // Wrong address, then a read request: both ignored.
        oe0 = oe_pulses; v0 = vld_cycles;
        i2c_start();
        send_byte(8'hA2, ack);
        chk("t2_wrong_addr_ack", ack, 0);
        send_byte(8'h12, ack);
        chk("t2_ignored_data_ack", ack, 0);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, ack);
        chk("t2_read_ack", ack, 0);
        chk("t2_busy", busy, 0);
        i2c_stop();
        tick(2);
        chk("t2_oe_pulses", oe_pulses - oe0, 0);
        chk("t2_vld_cycles", vld_cycles - v0, 0);

        // Consumer stalled: first byte held, second NACKed with overrun.
        rx_ready = 1'b0;
        ov0 = ovr_pulses;
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t3_addr_ack", ack, 1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, ack);
        chk("t3_first_ack", ack, 1);
        send_byte(8'hC3, ack);
        chk("t3_second_ack", ack, 0);
        chk("t3_overrun", ovr_pulses - ov0, 1);
        chk("t3_held_valid", rx_valid, 1);
        chk("t3_held_data", rx_data, 8'h3C);
        i2c_stop();
        rx_ready = 1'b1;
        tick(3);
        chk("t3_valid_cleared", rx_valid, 0);
        chk("t3_queue", exp_q.size(), 0);

        // STOP after a partial byte discards it.
        v0 = vld_cycles;
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t4_addr_ack", ack, 1);
        send_bit(1'b1, d); send_bit(1'b0, d); send_bit(1'b1, d); send_bit(1'b0, d);
        i2c_stop();
        tick(2);
        chk("t4_rx_valid", rx_valid, 0);
        chk("t4_sda_oe", sda_oe, 0);
        chk("t4_busy", busy, 0);
        chk("t4_vld_cycles", vld_cycles - v0, 0);

        // Repeated START mid-byte, then a normal write of 0x55.
        v0 = vld_cycles;
        i2c_start();
        send_byte(8'hA0, ack);
        send_bit(1'b1, d); send_bit(1'b1, d); send_bit(1'b0, d);
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t5_addr_ack", ack, 1);
        exp_q.push_back(8'h55);
        send_byte(8'h55, ack);
        chk("t5_data_ack", ack, 1);
        i2c_stop();
        tick(2);
        chk("t5_vld_cycles", vld_cycles - v0, 1);
        chk("t5_queue", exp_q.size(), 0);

        // Reset asserted while the target drives an ACK.
        rx_ready = 1'b0;
        b99 = 8'h99;
        i2c_start();
        send_byte(8'hA0, ack);
        for (int i = 7; i >= 0; i--) send_bit(b99[i], d);
        tick(3);
        sda_drv = 1'b1;
        for (int k = 0; k < 10 && !sda_oe; k++) tick(1);
        chk("t6_oe_driven", sda_oe, 1);
        chk("t6_valid_before_rst", rx_valid, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_sda_oe", sda_oe, 0);
        chk("t6_rst_rx_valid", rx_valid, 0);
        chk("t6_rst_busy", busy, 0);
        tick(2);
        scl_drv = 1'b1;
        tick(4);
        reset = 1'b1;
        rx_ready = 1'b1;
        tick(4);
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t6_addr_ack", ack, 1);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, ack);
        chk("t6_data_ack", ack, 1);
        i2c_stop();
        tick(2);

        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
